// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t  : sequencer states (IDLE -> ACCESS -> RESP)
//   PORT_IF/LS   : requester indices (0 = instruction fetch, 1 = load/store)
//   DEF_*        : default geometry of the MIPS data memory
//   other_port() : the port that gets priority after a grant to idx
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MEM_SIZE = 1024;

  function automatic logic other_port(input logic idx);
    return (idx == PORT_IF) ? PORT_LS : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way request picker.
//   req0, req1 : pending requests (port 0 = fetch, port 1 = load/store)
//   prio       : port that wins when both request
//   gnt_valid  : at least one request is pending
//   gnt_idx    : winning port index
// Build option ARB_FIXED_PRIORITY_EN: load/store always wins contention and
// prio is ignored.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic gnt_valid,
  output logic gnt_idx
);

  assign gnt_valid = req0 | req1;

`ifdef ARB_FIXED_PRIORITY_EN
  // prio is kept on the port list so both builds share one instantiation.
  logic unused_prio;
  assign unused_prio = prio;

  assign gnt_idx = req1 ? PORT_LS : PORT_IF;
`else
  always_comb begin
    gnt_idx = PORT_IF;
    if (req0 && req1) gnt_idx = prio;
    else if (req1)    gnt_idx = PORT_LS;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester sequencer in front of the single-port data
// memory. Each transaction takes IDLE (grant) -> ACCESS (memory pins driven
// for one cycle) -> RESP (ack pulse), so peak rate is one per 3 cycles.
// Out-of-range writes are suppressed and out-of-range reads return 0; both
// raise err with the ack.
//   clk, rst            : clock, asynchronous active-high reset
//   req/we/addr/wdata N : requester N inputs, held until ackN
//   ackN                : one-cycle completion pulse
//   rdata, err          : shared response, valid only with an ack
//   mem_*               : combinational-memory interface (all registered here)
// Build option ARB_FIXED_PRIORITY_EN: port 1 always wins ties, no prio flop.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_corrupted
);

  arb_state_t state;

  logic              prio;
  logic              gnt_valid;
  logic              gnt_idx;

  // Winner's request, muxed so it can be latched at the grant edge.
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  // Latched at grant; consumed at the end of ACCESS.
  logic              lat_idx;
  logic              lat_rd;
  logic              lat_oor;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_we    = gnt_idx ? we1    : we0;
    sel_addr  = gnt_idx ? addr1  : addr0;
    sel_wdata = gnt_idx ? wdata1 : wdata0;
    // Widen both sides so MEM_SIZE >= 2**ADDR_W cannot truncate.
    sel_oor   = 64'(sel_addr) >= 64'(MEM_SIZE);
  end

`ifdef ARB_FIXED_PRIORITY_EN
  assign prio = PORT_LS;
`else
  // Port 1 wins the first tie after reset; every grant hands priority over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          prio <= PORT_LS;
    else if (state == IDLE && gnt_valid) prio <= other_port(gnt_idx);
  end
`endif

  // All outputs are flops, so an async reset drops the memory enables at
  // once and aborts any transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      lat_idx          <= PORT_IF;
      lat_rd           <= 1'b0;
      lat_oor          <= 1'b0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      rdata            <= '0;
      err              <= 1'b0;
      mem_address      <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_data_in      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            state            <= ACCESS;
            lat_idx          <= gnt_idx;
            lat_rd           <= ~sel_we;
            lat_oor          <= sel_oor;
            mem_address      <= sel_addr;
            mem_read_enable  <= ~sel_we & ~sel_oor;
            mem_write_enable <=  sel_we & ~sel_oor;
            mem_data_in      <= (sel_we && !sel_oor) ? sel_wdata : '0;
          end
        end
        ACCESS: begin
          state            <= RESP;
          rdata            <= (lat_rd && !lat_oor) ? mem_data_out : '0;
          err              <= lat_oor | (lat_rd & mem_corrupted);
          ack0             <= (lat_idx == PORT_IF);
          ack1             <= (lat_idx == PORT_LS);
          mem_address      <= '0;
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_data_in      <= '0;
        end
        RESP: begin
          // rdata/err hold until the next ACCESS overwrites them.
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter with a
// behavioural memory and a queue-based arbitration/memory reference model.
module tb_mem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int MEM_SIZE = 1024;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk, rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_enable, mem_write_enable;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_corrupted;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_corrupted(mem_corrupted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: words never written read back a fixed hash.
  logic [31:0] mem [0:1023];
  bit          mem_valid [0:1023];
  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] mem_peek(input int a);
    return mem_valid[a] ? mem[a] : init_val(a);
  endfunction
  assign mem_data_out = mem_valid[mem_address[9:0]] ? mem[mem_address[9:0]]
                                                    : init_val(int'(mem_address[9:0]));
  always @(posedge clk)
    if (mem_write_enable) begin
      mem[mem_address[9:0]]       <= mem_data_in;
      mem_valid[mem_address[9:0]] <= 1'b1;
    end

  // Reference model state
  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } txn_t;
  typedef struct { int port; logic [DATA_W-1:0] rdata; logic err; int cyc; } res_t;
  logic [31:0] model_mem [0:1023];
  bit          model_prio;
  txn_t pq0[$], pq1[$];
  res_t expq[$], comps[$];

  int vectors = 0;
  int miscompares = 0;

  function automatic txn_t mk(input logic we, input int addr, input logic [31:0] wd);
    txn_t t;
    t.we = we; t.addr = ADDR_W'(addr); t.wdata = wd;
    return t;
  endfunction

  // Expected completion order from the arbitration rules: with both
  // requesters always re-presenting, every decision sees all non-empty ports.
  task automatic predict();
    txn_t m0[$], m1[$], t;
    res_t e;
    int p;
    m0 = pq0; m1 = pq1; expq.delete();
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) p = FIXED ? 1 : int'(model_prio);
      else p = (m1.size() > 0) ? 1 : 0;
      t = (p == 1) ? m1.pop_front() : m0.pop_front();
      e.port  = p;
      e.err   = (int'(t.addr) >= MEM_SIZE);
      e.rdata = (!t.we && !e.err) ? model_mem[int'(t.addr)] : 32'h0;
      if (t.we && !e.err) model_mem[int'(t.addr)] = t.wdata;
      e.cyc   = 2 + 3 * expq.size();
      expq.push_back(e);
      model_prio = (p == 0);
    end
  endtask

  task automatic present();
    req0 = (pq0.size() > 0); req1 = (pq1.size() > 0);
    if (pq0.size() > 0) begin we0 = pq0[0].we; addr0 = pq0[0].addr; wdata0 = pq0[0].wdata; end
    if (pq1.size() > 0) begin we1 = pq1[0].we; addr1 = pq1[0].addr; wdata1 = pq1[0].wdata; end
  endtask

  // Requester driver + pin monitor; starts and ends 1 time unit after a posedge.
  task automatic run_engine(input int budget);
    int n = 0;
    bit prev_en = 0, en, g0, g1;
    res_t r;
    comps.delete();
    present();
    while ((pq0.size() > 0 || pq1.size() > 0) && n < budget) begin
      @(negedge clk);
      en = mem_read_enable | mem_write_enable;
      vectors++;
      if ((mem_read_enable && mem_write_enable) || (en && prev_en) ||
          (mem_write_enable && int'(mem_address) >= MEM_SIZE) ||
          (!mem_write_enable && mem_data_in !== 32'h0) || (ack0 && ack1)) begin
        miscompares++;
        $display("FAIL pins: re=%b we=%b addr=%0d din=%h ack0=%b ack1=%b prev_en=%b",
                 mem_read_enable, mem_write_enable, mem_address, mem_data_in, ack0, ack1, prev_en);
      end
      prev_en = en;
      g0 = ack0; g1 = ack1;
      if (g0 || g1) begin
        r.port = g1 ? 1 : 0; r.rdata = rdata; r.err = err; r.cyc = n;
        comps.push_back(r);
      end
      @(posedge clk); #1; n++;
      if (g0 && pq0.size() > 0) void'(pq0.pop_front());
      if (g1 && pq1.size() > 0) void'(pq1.pop_front());
      present();
    end
    req0 = 0; req1 = 0;
    if (pq0.size() > 0 || pq1.size() > 0) begin
      miscompares++;
      $display("FAIL engine_timeout: %0d/%0d txns still pending after %0d cycles, want 0",
               pq0.size(), pq1.size(), n);
      pq0.delete(); pq1.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; mem_corrupted = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, rdata, err, mem_address, mem_read_enable, mem_write_enable, mem_data_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b%b rdata=%h err=%b addr=%h re=%b we=%b din=%h, want all 0",
               ack0, ack1, rdata, err, mem_address, mem_read_enable, mem_write_enable, mem_data_in);
    end
    rst = 0;
    @(posedge clk); #1;
    model_prio = 1;
  endtask

  task automatic test_write_read();
    req1 = 1; we1 = 1; addr1 = 5; wdata1 = 32'hDEADBEEF;
    @(posedge clk); #1;   // granted: ACCESS
    vectors++;
    if (mem_write_enable !== 1 || mem_read_enable !== 0 || mem_address !== 5 ||
        mem_data_in !== 32'hDEADBEEF || ack1 !== 0) begin
      miscompares++;
      $display("FAIL wr_access: we=%b re=%b addr=%0d din=%h ack1=%b, want 1 0 5 deadbeef 0",
               mem_write_enable, mem_read_enable, mem_address, mem_data_in, ack1);
    end
    @(posedge clk); #1;   // RESP
    vectors++;
    if (ack1 !== 1 || ack0 !== 0 || err !== 0 || mem_write_enable !== 0) begin
      miscompares++;
      $display("FAIL wr_resp: ack1=%b ack0=%b err=%b we=%b, want 1 0 0 0", ack1, ack0, err, mem_write_enable);
    end
    req1 = 0; we1 = 0;
    model_mem[5] = 32'hDEADBEEF;
    @(posedge clk); #1;   // IDLE
    vectors++;
    if (ack1 !== 0) begin miscompares++; $display("FAIL wr_ack_len: ack1=%b, want 0", ack1); end
    req0 = 1; we0 = 0; addr0 = 5;
    @(posedge clk); #1;
    vectors++;
    if (mem_read_enable !== 1 || mem_write_enable !== 0 || mem_address !== 5) begin
      miscompares++;
      $display("FAIL rd_access: re=%b we=%b addr=%0d, want 1 0 5", mem_read_enable, mem_write_enable, mem_address);
    end
    @(posedge clk); #1;
    vectors++;
    if (ack0 !== 1 || ack1 !== 0 || rdata !== 32'hDEADBEEF || err !== 0) begin
      miscompares++;
      $display("FAIL rd_resp: ack0=%b ack1=%b rdata=%h err=%b, want 1 0 deadbeef 0", ack0, ack1, rdata, err);
    end
    req0 = 0;
    @(posedge clk); #1;
    model_prio = 1;
  endtask

  task automatic test_tie();
    for (int r = 0; r < 3; r++) begin
      pq0.push_back(mk(0, $urandom_range(0, 63), 0));
      for (int k = 0; k < ((r == 1) ? 2 : 1); k++) pq1.push_back(mk(0, $urandom_range(0, 63), 0));
      predict();
      run_engine(20);
      vectors++;
      if (comps.size() != expq.size()) begin
        miscompares++; $display("FAIL tie_count: got %0d acks, want %0d", comps.size(), expq.size());
      end
      foreach (expq[i]) if (i < comps.size()) begin
        vectors++;
        if (comps[i].port != expq[i].port || comps[i].rdata !== expq[i].rdata ||
            comps[i].err !== expq[i].err || comps[i].cyc != expq[i].cyc) begin
          miscompares++;
          $display("FAIL tie[%0d.%0d]: got port=%0d rdata=%h err=%b cyc=%0d, want port=%0d rdata=%h err=%b cyc=%0d",
                   r, i, comps[i].port, comps[i].rdata, comps[i].err, comps[i].cyc,
                   expq[i].port, expq[i].rdata, expq[i].err, expq[i].cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) pq1.push_back(mk(k[0], 100 + k, $urandom));
    for (int k = 0; k < 3; k++) pq0.push_back(mk(0, 100 + k, 0));
    predict();
    run_engine(40);
    vectors++;
    if (comps.size() != expq.size()) begin
      miscompares++; $display("FAIL b2b_count: got %0d acks, want %0d", comps.size(), expq.size());
    end
    foreach (expq[i]) if (i < comps.size()) begin
      vectors++;
      if (comps[i].port != expq[i].port || comps[i].rdata !== expq[i].rdata ||
          comps[i].err !== expq[i].err || comps[i].cyc != expq[i].cyc) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got port=%0d rdata=%h err=%b cyc=%0d, want port=%0d rdata=%h err=%b cyc=%0d",
                 i, comps[i].port, comps[i].rdata, comps[i].err, comps[i].cyc,
                 expq[i].port, expq[i].rdata, expq[i].err, expq[i].cyc);
      end
    end
  endtask

  task automatic test_out_of_range();
    pq1.push_back(mk(1, 1024, 32'h1234));
    pq1.push_back(mk(1, 1023, 32'hCAFE_F00D));
    pq0.push_back(mk(0, 4000, 0));
    pq0.push_back(mk(0, 1023, 0));
    pq0.push_back(mk(0, 1024, 0));
    predict();
    run_engine(30);
    vectors++;
    if (comps.size() != expq.size()) begin
      miscompares++; $display("FAIL oor_count: got %0d acks, want %0d", comps.size(), expq.size());
    end
    foreach (expq[i]) if (i < comps.size()) begin
      vectors++;
      if (comps[i].port != expq[i].port || comps[i].rdata !== expq[i].rdata ||
          comps[i].err !== expq[i].err || comps[i].cyc != expq[i].cyc) begin
        miscompares++;
        $display("FAIL oor[%0d]: got port=%0d rdata=%h err=%b cyc=%0d, want port=%0d rdata=%h err=%b cyc=%0d",
                 i, comps[i].port, comps[i].rdata, comps[i].err, comps[i].cyc,
                 expq[i].port, expq[i].rdata, expq[i].err, expq[i].cyc);
      end
    end
    // An unsuppressed write to 1024 would alias onto word 0 of this memory.
    vectors++;
    if (mem_peek(0) !== model_mem[0]) begin
      miscompares++; $display("FAIL oor_alias: mem[0]=%h, want %h", mem_peek(0), model_mem[0]);
    end
  endtask

  task automatic test_addr_latch();
    req0 = 1; we0 = 0; addr0 = 5;
    @(posedge clk); #1;   // ACCESS: change everything, corrupt the read
    addr0 = 7; we0 = 1; wdata0 = 32'h0BAD_0BAD; mem_corrupted = 1;
    #1;
    vectors++;
    if (mem_address !== 5 || mem_read_enable !== 1 || mem_write_enable !== 0) begin
      miscompares++;
      $display("FAIL latch_access: addr=%0d re=%b we=%b, want 5 1 0", mem_address, mem_read_enable, mem_write_enable);
    end
    @(posedge clk); #1;
    vectors++;
    if (ack0 !== 1 || rdata !== model_mem[5] || err !== 1) begin
      miscompares++;
      $display("FAIL latch_resp: ack0=%b rdata=%h err=%b, want 1 %h 1", ack0, rdata, err, model_mem[5]);
    end
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; mem_corrupted = 0;
    @(posedge clk); #1;
    model_prio = 1;
  endtask

  task automatic test_reset_abort();
    req1 = 1; we1 = 1; addr1 = 9; wdata1 = $urandom;
    @(posedge clk); #1;   // ACCESS of the write
    vectors++;
    if (mem_write_enable !== 1) begin
      miscompares++; $display("FAIL abort_pre: we=%b, want 1", mem_write_enable);
    end
    #1 rst = 1; #1;
    vectors++;
    if ({ack0, ack1, rdata, err, mem_address, mem_read_enable, mem_write_enable, mem_data_in} !== '0) begin
      miscompares++;
      $display("FAIL abort_pins: ack=%b%b err=%b addr=%h re=%b we=%b din=%h, want all 0",
               ack0, ack1, err, mem_address, mem_read_enable, mem_write_enable, mem_data_in);
    end
    req1 = 0; we1 = 0;
    @(negedge clk); rst = 0;
    model_mem[9] = mem_peek(9);
    model_prio = 1;
    @(posedge clk); #1;
    vectors++;
    if (ack0 !== 0 || ack1 !== 0 || mem_read_enable !== 0 || mem_write_enable !== 0) begin
      miscompares++; $display("FAIL abort_noack: ack=%b%b re=%b we=%b, want 0", ack0, ack1, mem_read_enable, mem_write_enable);
    end
    // The tie right after reset must go to port 1 in either build.
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 3; addr1 = 4;
    @(posedge clk); #1;
    vectors++;
    if (mem_read_enable !== 1 || mem_address !== 4) begin
      miscompares++; $display("FAIL abort_tie: re=%b addr=%0d, want 1 4", mem_read_enable, mem_address);
    end
    @(posedge clk); #1;
    vectors++;
    if (ack1 !== 1 || ack0 !== 0 || rdata !== model_mem[4]) begin
      miscompares++; $display("FAIL abort_tie_resp: ack=%b%b rdata=%h, want 01 %h", ack0, ack1, rdata, model_mem[4]);
    end
    req1 = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (mem_read_enable !== 1 || mem_address !== 3) begin
      miscompares++; $display("FAIL abort_second: re=%b addr=%0d, want 1 3", mem_read_enable, mem_address);
    end
    @(posedge clk); #1;
    vectors++;
    if (ack0 !== 1 || rdata !== model_mem[3]) begin
      miscompares++; $display("FAIL abort_second_resp: ack0=%b rdata=%h, want 1 %h", ack0, rdata, model_mem[3]);
    end
    req0 = 0;
    @(posedge clk); #1;
    model_prio = 1;
  endtask

  task automatic test_random();
    int diffs = 0;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 8)); k++)
        pq0.push_back(mk($urandom_range(0, 1) == 1,
                         ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 4095) : $urandom_range(0, 31), $urandom));
      for (int k = 0; k < int'($urandom_range(1, 8)); k++)
        pq1.push_back(mk($urandom_range(0, 1) == 1,
                         ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 4095) : $urandom_range(0, 31), $urandom));
      predict();
      run_engine(3 * expq.size() + 8);
      vectors++;
      if (comps.size() != expq.size()) begin
        miscompares++; $display("FAIL rand_count[%0d]: got %0d acks, want %0d", it, comps.size(), expq.size());
      end
      foreach (expq[i]) if (i < comps.size()) begin
        vectors++;
        if (comps[i].port != expq[i].port || comps[i].rdata !== expq[i].rdata ||
            comps[i].err !== expq[i].err || comps[i].cyc != expq[i].cyc) begin
          miscompares++;
          $display("FAIL rand[%0d.%0d]: got port=%0d rdata=%h err=%b cyc=%0d, want port=%0d rdata=%h err=%b cyc=%0d",
                   it, i, comps[i].port, comps[i].rdata, comps[i].err, comps[i].cyc,
                   expq[i].port, expq[i].rdata, expq[i].err, expq[i].cyc);
        end
      end
    end
    for (int a = 0; a < MEM_SIZE; a++) if (mem_peek(a) !== model_mem[a]) diffs++;
    vectors++;
    if (diffs != 0) begin miscompares++; $display("FAIL mem_image: %0d words differ, want 0", diffs); end
  endtask

  initial begin
    for (int a = 0; a < MEM_SIZE; a++) model_mem[a] = init_val(a);
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_out_of_range();
    test_addr_latch();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
